// File: rtl/pll_pkg.sv
// Shared types and defaults for the phase error detector: FSM state encoding
// and the default counter width / timeout.
package pll_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REF_FIRST = 2'd1,
    FB_FIRST  = 2'd2
  } pd_state_t;

  localparam int CNT_WIDTH_DEF = 8;
  localparam int MAX_WAIT_DEF  = 200;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge flag for a clock sampled as data, with an optional two-flop
// synchronizer in front (PHASE_DET_SYNC_EN).
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_in,
  output logic o_rise
);

  logic w_in;

`ifdef PHASE_DET_SYNC_EN
  localparam logic [1:0] ARM_CYC = 2'd3;
  logic r_s1, r_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_in;
      r_s2 <= r_s1;
    end
  end

  assign w_in = r_s2;
`else
  localparam logic [1:0] ARM_CYC = 2'd1;
  assign w_in = i_in;
`endif

  logic       r_prev;
  logic [1:0] r_arm;

  // Edges are ignored until the history holds a real post-reset sample, so an
  // input that is already high when reset releases is not seen as a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= 1'b0;
      r_arm  <= 2'd0;
    end else begin
      r_prev <= w_in;
      if (r_arm != ARM_CYC) r_arm <= r_arm + 2'd1;
    end
  end

  assign o_rise = (r_arm == ARM_CYC) & w_in & ~r_prev;

endmodule

// File: rtl/phase_error_detector.sv
// Measures the cycle distance between rising edges of ref_in and fb_in and
// reports it as a signed error. Optional input synchronizers: PHASE_DET_SYNC_EN.
module phase_error_detector
  import pll_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int MAX_WAIT  = MAX_WAIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ref_in,
  input  logic                 fb_in,
  output logic [CNT_WIDTH:0]   err_out,
  output logic                 err_valid,
  output logic                 up,
  output logic                 dn,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] MAXW = CNT_WIDTH'(MAX_WAIT);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic w_ref_rise, w_fb_rise;

  edge_detect u_ref_edge (.clk(clk), .reset(reset), .i_in(ref_in), .o_rise(w_ref_rise));
  edge_detect u_fb_edge  (.clk(clk), .reset(reset), .i_in(fb_in),  .o_rise(w_fb_rise));

  pd_state_t            r_state, w_nstate;
  logic [CNT_WIDTH-1:0] r_cnt, w_ncnt, w_inc;
  logic [CNT_WIDTH:0]   r_err, w_nerr, w_mag;
  logic                 r_valid, r_up, r_dn, r_to;
  logic                 w_load, w_neg, w_to, w_partner, w_leader;

  assign w_inc = (r_cnt == '1) ? r_cnt : r_cnt + ONE;
  assign w_mag = {1'b0, r_cnt};

  always_comb begin
    w_nstate  = r_state;
    w_ncnt    = r_cnt;
    w_load    = 1'b0;
    w_neg     = 1'b0;
    w_to      = 1'b0;
    w_nerr    = '0;
    w_partner = (r_state == REF_FIRST) ? w_fb_rise  : w_ref_rise;
    w_leader  = (r_state == REF_FIRST) ? w_ref_rise : w_fb_rise;
    case (r_state)
      IDLE: begin
        w_ncnt = '0;
        if (w_ref_rise && w_fb_rise) begin
          w_load = 1'b1;
        end else if (w_ref_rise) begin
          w_nstate = REF_FIRST;
          w_ncnt   = ONE;
        end else if (w_fb_rise) begin
          w_nstate = FB_FIRST;
          w_ncnt   = ONE;
        end
      end
      REF_FIRST, FB_FIRST: begin
        // Partner edge wins over a same-cycle leader edge; timeout wins over slip.
        if (w_partner || (r_cnt == MAXW)) begin
          w_load   = 1'b1;
          w_to     = ~w_partner;
          w_neg    = (r_state == FB_FIRST);
          w_nerr   = w_neg ? (~w_mag + 1'b1) : w_mag;
          w_nstate = IDLE;
          w_ncnt   = '0;
        end else if (w_leader) begin
          w_ncnt = ONE;
        end else begin
          w_ncnt = w_inc;
        end
      end
      default: begin
        w_nstate = IDLE;
        w_ncnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= '0;
      r_valid <= 1'b0;
      r_to    <= 1'b0;
      r_up    <= 1'b0;
      r_dn    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_valid <= w_load;
      r_to    <= w_to;
      r_up    <= (w_nstate == REF_FIRST);
      r_dn    <= (w_nstate == FB_FIRST);
      if (w_load) r_err <= w_nerr;
    end
  end

  assign err_out   = r_err;
  assign err_valid = r_valid;
  assign timeout   = r_to;
  assign up        = r_up;
  assign dn        = r_dn;

endmodule

// File: tb/tb_phase_error_detector.sv
// Self-checking bench for phase_error_detector (default build, no synchronizers):
// directed scenarios plus randomized edge streams against a timestamp model.
module tb_phase_error_detector;

  localparam int W  = 8;
  localparam int MW = 200;

  logic         clk = 1'b0;
  logic         reset;
  logic         ref_in, fb_in;
  logic [W:0]   err_out;
  logic         err_valid, up, dn, timeout;

  int checks = 0;
  int errors = 0;

  phase_error_detector #(.CNT_WIDTH(W), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .ref_in(ref_in), .fb_in(fb_in),
    .err_out(err_out), .err_valid(err_valid), .up(up), .dn(dn), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Model: a measurement is "open since cycle m_start"; the error is simply
  // the number of cycles elapsed between the leader edge and the partner edge.
  int mc = 0;
  bit m_open, m_lref, m_valid, m_to, m_armed, m_pr, m_pf;
  int m_start, m_err;

  function automatic logic [W+4:0] exp_vec();
    logic [W:0] e;
    e = m_err[W:0];
    return {m_open & m_lref, m_open & ~m_lref, m_valid, m_to, e};
  endfunction

  function automatic logic [W+4:0] obs_vec();
    return {up, dn, err_valid, timeout, err_out};
  endfunction

  task automatic model_reset();
    m_open = 0; m_lref = 0; m_valid = 0; m_to = 0;
    m_armed = 0; m_pr = 0; m_pf = 0; m_err = 0; m_start = 0;
  endtask

  // Drive one cycle of inputs, advance the model, and land 1 time unit past the edge.
  task automatic tick(input bit r, input bit f);
    bit rr, fr, partner, leader;
    int el;
    ref_in = r;
    fb_in  = f;
    rr = m_armed && r && !m_pr;
    fr = m_armed && f && !m_pf;
    m_pr = r; m_pf = f; m_armed = 1;
    m_valid = 0; m_to = 0;
    if (!m_open) begin
      if (rr && fr) begin
        m_err = 0; m_valid = 1;
      end else if (rr || fr) begin
        m_open = 1; m_lref = rr; m_start = mc;
      end
    end else begin
      partner = m_lref ? fr : rr;
      leader  = m_lref ? rr : fr;
      el = mc - m_start;
      if (partner || el >= MW) begin
        m_err = m_lref ? el : -el;
        m_valid = 1; m_to = !partner; m_open = 0;
      end else if (leader) begin
        m_start = mc;
      end
    end
    mc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", obs_vec());
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  // Runs an (r,f) pattern, bit i applied in relative cycle i, then checks the final error.
  task automatic test_pattern(input string nm, input logic [31:0] rs, input logic [31:0] fs,
                              input int n, input logic [W:0] final_err);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tick(rs[i], fs[i]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL %s[%0d]: got %h expected %h", nm, i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (err_valid !== 1'b1 || err_out !== final_err || up !== 1'b0 || dn !== 1'b0) begin
      errors++;
      $display("FAIL %s_final: valid=%b err=%0d expected valid=1 err=%0d",
               nm, err_valid, $signed(err_out), $signed(final_err));
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    logic [W:0] e200;
    e200 = 9'd200;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    for (int i = 0; i <= MW; i++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL timeout_seq[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (timeout !== 1'b1 || err_valid !== 1'b1 || err_out !== e200 || up !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: to=%b valid=%b err=%0d expected to=1 valid=1 err=200",
               timeout, err_valid, err_out);
    end
    tick(1'b1, 1'b0);
    checks++;
    if (timeout !== 1'b0 || err_valid !== 1'b0 || err_out !== e200 || up !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: to=%b valid=%b err=%0d expected to=0 valid=0 err=200",
               timeout, err_valid, err_out);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got %h expected 0", obs_vec());
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    // ref still high after release must not start a measurement
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, (i >= 4));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid_post[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
  endtask

  task automatic test_random(input int n, input int div);
    bit r, f;
    r = 0; f = 0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(div - 1, 0) == 0) r = ~r;
      if ($urandom_range(div - 1, 0) == 0) f = ~f;
      tick(r, f);
      checks++;
      if (obs_vec() !== exp_vec() || (up && dn)) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; ref_in = 1'b0; fb_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    // ref rises rel 0, fb rel 5 -> +5
    test_pattern("ref_lead", 32'h0000_003F, 32'h0000_0020, 6, 9'd5);
    // fb rises rel 0, ref rel 3 -> -3
    test_pattern("fb_lead",  32'h0000_0008, 32'h0000_000F, 4, 9'h1FD);
    // both rise in the same cycle -> 0
    test_pattern("simult",   32'h0000_0001, 32'h0000_0001, 1, 9'd0);
    // ref rises rel 0 and 4, fb rel 7 -> +3
    test_pattern("slip",     32'h0000_00F3, 32'h0000_0080, 8, 9'd3);
    // fb lead with same-cycle fb re-edge and ref partner: partner wins -> -2
    test_pattern("partner_wins", 32'h0000_0004, 32'h0000_0005, 3, 9'h1FE);
    test_timeout();
    test_reset_mid();
    test_random(2000, 8);
    test_random(3000, 300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
